// File: rtl/delivery_game_uc.sv
// delivery_game_uc: control unit for the delivery game (measurement loop, pause, game over, sensor fault)
module delivery_game_uc (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       pausar,
   input  logic       game_over,
   input  logic       velocity_ready,
   input  logic       velocity_timeout,
   input  logic       end_delay,
   output logic       zera_fd,
   output logic       reset_ultrasonico,
   output logic       get_velocity,
   output logic       count_map,
   output logic       reset_delay,
   output logic       conta_delay,
   output logic       reset_timeout,
   output logic       conta_timeout,
   output logic       jogando,
   output logic       fim_jogo,
   output logic       sensor_fault,
   output logic [3:0] db_estado
);
   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      PREPARA = 4'd1,
      MEDIR   = 4'd2,
      ESPERA  = 4'd3,
      TIMEOUT = 4'd4,
      DELAY   = 4'd5,
      PAUSA   = 4'd6,
      FIM     = 4'd7
   } state_t;

   state_t     state, next;
   logic [1:0] faults, faults_next;

   // state register
   always_ff @(posedge clock or posedge reset)
      if (reset) state <= IDLE;
      else       state <= next;

   // next state; a collision while playing overrides every other transition
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (iniciar) next = PREPARA;
         PREPARA: next = MEDIR;
         MEDIR:   next = ESPERA;
         ESPERA:  next = velocity_ready ? DELAY : velocity_timeout ? TIMEOUT : ESPERA;
         TIMEOUT: next = DELAY;
         DELAY:   next = end_delay ? MEDIR : pausar ? PAUSA : DELAY;
         PAUSA:   next = iniciar ? PREPARA : pausar ? DELAY : PAUSA;
         FIM:     if (iniciar) next = PREPARA;
         default: next = IDLE;
      endcase
      if (jogando && game_over) next = FIM;
   end

   // Moore output decode
   always_comb begin
      zera_fd           = state == PREPARA;
      reset_ultrasonico = state == PREPARA || state == TIMEOUT;
      get_velocity      = state == MEDIR;
      reset_timeout     = state == MEDIR;
      reset_delay       = state == MEDIR;
      conta_timeout     = state == ESPERA;
      conta_delay       = state == DELAY;
      jogando           = state == MEDIR || state == ESPERA || state == TIMEOUT || state == DELAY;
      count_map         = jogando;
      fim_jogo          = state == FIM;
      db_estado         = state;
   end

   // consecutive-timeout count: a good measurement or a new game clears it
   always_comb
      faults_next = (state == PREPARA || (state == ESPERA && next == DELAY)) ? 2'd0 :
                    (state == ESPERA && next == TIMEOUT && faults != 2'd3) ? faults + 2'd1 : faults;

   // fault counter and registered fault flag
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         faults       <= 2'd0;
         sensor_fault <= 1'b0;
      end else begin
         faults       <= faults_next;
         sensor_fault <= faults_next == 2'd3;
      end
endmodule

// File: tb/tb_delivery_game_uc.sv
// tb_delivery_game_uc: directed and random checks of delivery_game_uc against a behavioural model
module tb_delivery_game_uc;
   logic clock, reset, iniciar, pausar, game_over, velocity_ready, velocity_timeout, end_delay;
   logic zera_fd, reset_ultrasonico, get_velocity, count_map, reset_delay, conta_delay;
   logic reset_timeout, conta_timeout, jogando, fim_jogo, sensor_fault;
   logic [3:0] db_estado;

   int passed = 0, total = 0;
   int m_state = 0, m_faults = 0;

   delivery_game_uc dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .pausar(pausar), .game_over(game_over),
      .velocity_ready(velocity_ready), .velocity_timeout(velocity_timeout), .end_delay(end_delay),
      .zera_fd(zera_fd), .reset_ultrasonico(reset_ultrasonico), .get_velocity(get_velocity),
      .count_map(count_map), .reset_delay(reset_delay), .conta_delay(conta_delay),
      .reset_timeout(reset_timeout), .conta_timeout(conta_timeout), .jogando(jogando),
      .fim_jogo(fim_jogo), .sensor_fault(sensor_fault), .db_estado(db_estado)
   );

   initial clock = 0;
   always #5 clock = ~clock;

   // game rules: 0 idle,1 prepare,2 measure,3 wait,4 timeout,5 delay,6 pause,7 end
   function automatic int rule_next(int s, bit i, bit p, bit g, bit r, bit t, bit e);
      if (s >= 2 && s <= 5 && g) return 7;
      if (s == 0 || s == 7) return i ? 1 : s;
      if (s == 1) return 2;
      if (s == 2) return 3;
      if (s == 3) return r ? 5 : (t ? 4 : 3);
      if (s == 4) return 5;
      if (s == 5) return e ? 2 : (p ? 6 : 5);
      if (s == 6) return i ? 1 : (p ? 5 : 6);
      return 0;
   endfunction

   // {zera_fd,reset_ultrasonico,get_velocity,count_map,reset_delay,conta_delay,reset_timeout,conta_timeout,jogando,fim_jogo}
   function automatic logic [9:0] rule_outputs(int s);
      logic [9:0] tbl [8] = '{10'b0000000000, 10'b1100000000, 10'b0011101010, 10'b0001000110,
                              10'b0101000010, 10'b0001010010, 10'b0000000000, 10'b0000000001};
      return tbl[s];
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h (state %0d, t=%0t)", tag, obs, exp, m_state, $time);
   endtask

   task automatic check_all();
      chk("db_estado", {28'd0, db_estado}, m_state);
      chk("outputs", {22'd0, zera_fd, reset_ultrasonico, get_velocity, count_map, reset_delay, conta_delay,
                      reset_timeout, conta_timeout, jogando, fim_jogo}, {22'd0, rule_outputs(m_state)});
      chk("sensor_fault", {31'd0, sensor_fault}, {31'd0, m_faults == 3});
   endtask

   task automatic step(bit i, bit p, bit g, bit r, bit t, bit e);
      int n;
      iniciar = i; pausar = p; game_over = g; velocity_ready = r; velocity_timeout = t; end_delay = e;
      @(posedge clock);
      n = rule_next(m_state, i, p, g, r, t, e);
      if (m_state == 1 || (m_state == 3 && n == 5)) m_faults = 0;
      else if (m_state == 3 && n == 4 && m_faults < 3) m_faults++;
      m_state = n;
      #1 check_all();
   endtask

   task automatic idle_step();
      step(0, 0, 0, 0, 0, 0);
   endtask

   // asynchronous reset applied between edges
   task automatic do_reset();
      #2 reset = 1;
      m_state = 0;
      m_faults = 0;
      #1 check_all();
      @(negedge clock) reset = 0;
   endtask

   initial begin
      reset = 1; iniciar = 0; pausar = 0; game_over = 0;
      velocity_ready = 0; velocity_timeout = 0; end_delay = 0;
      #2 check_all();
      @(negedge clock) reset = 0;
      idle_step(); idle_step();
      // start: prepare, measure, wait
      step(1, 0, 0, 0, 0, 0); idle_step(); idle_step(); idle_step();
      // good measurement, delay, next measurement
      step(0, 0, 0, 1, 0, 0); idle_step(); idle_step();
      step(0, 0, 0, 0, 0, 1); idle_step();
      // four consecutive timeouts: flag rises on the third and saturates
      repeat (4) begin
         step(0, 0, 0, 0, 1, 0); idle_step();
         step(0, 0, 0, 0, 0, 1); idle_step();
      end
      step(0, 0, 0, 1, 0, 0);
      // ready and timeout together: ready wins, count stays clear
      step(0, 0, 0, 0, 0, 1); idle_step();
      step(0, 0, 0, 0, 1, 0); step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1); idle_step();
      step(0, 0, 0, 1, 1, 0);
      // pause, collision ignored while paused, resume
      step(0, 1, 0, 0, 0, 0); idle_step();
      step(0, 0, 1, 0, 0, 1); step(0, 1, 0, 0, 0, 0);
      // collision in wait, restart, reset mid-delay
      step(0, 0, 0, 0, 0, 1); idle_step();
      step(0, 0, 1, 1, 0, 0); idle_step();
      step(1, 0, 0, 0, 0, 0); idle_step(); idle_step();
      step(0, 0, 0, 1, 0, 0);
      do_reset();
      idle_step();
      // restart from pause
      step(1, 0, 0, 0, 0, 0); idle_step(); idle_step();
      step(0, 0, 0, 1, 0, 0); step(0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0); idle_step();
      // random play
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(299) == 0) do_reset();
         else step($urandom_range(15) == 0, $urandom_range(7) == 0, $urandom_range(40) == 0,
                   $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
